// File: rtl/ula_pkg.sv
// Shared constants for the ula_nbits ALU: opcodes, FSM state encoding, flag bit positions.
package ula_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_DIV = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10
    } state_t;

    // flags = {err, dz, ovf, zero}
    localparam int FLAG_ZERO = 0;
    localparam int FLAG_OVF  = 1;
    localparam int FLAG_DZ   = 2;
    localparam int FLAG_ERR  = 3;

endpackage

// File: rtl/ula_seq_core.sv
// Iterative datapath for ula_nbits: shift-add multiplier and, with ULA_DIV_EN, a restoring divider.
// One partial product / quotient bit per step; result is the combinational value after the current step.
module ula_seq_core #(
    parameter  int WIDTH = 4,
    localparam int OUT_W = 2*WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
`ifdef ULA_DIV_EN
    input  logic             is_div,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [OUT_W-1:0] result,
    output logic             last
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] addend;
    logic [WIDTH-1:0]   sh;
    logic [WIDTH-1:0]   sh_next;
    logic [WIDTH-1:0]   opnd;
`ifdef ULA_DIV_EN
    logic               div_mode;
    logic [WIDTH:0]     r_shift;
    logic [WIDTH:0]     diff;
`endif

    assign last = (cnt == CNT_W'(WIDTH - 1));

    // NOTE: sequential state uses <= so every register sees pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= last ? '0 : cnt + CNT_W'(1);
        end
    end

    // NOTE: datapath registers carry no reset; they are always loaded before the FSM lets a result out.
    always_ff @(posedge clk) begin
        if (load) begin
            acc <= '0;
`ifdef ULA_DIV_EN
            div_mode <= is_div;
            sh       <= is_div ? a : b;
            opnd     <= is_div ? b : a;
`else
            sh   <= b;
            opnd <= a;
`endif
        end else if (step) begin
            acc <= acc_next;
            sh  <= sh_next;
        end
    end

    always_comb begin
        addend   = {{WIDTH{1'b0}}, opnd} << cnt;
        acc_next = sh[0] ? acc + addend : acc;
        sh_next  = sh >> 1;
        result   = {1'b0, acc_next};
`ifdef ULA_DIV_EN
        // Dividend bits leave the top of sh while quotient bits enter at the bottom.
        r_shift = {acc[WIDTH-1:0], sh[WIDTH-1]};
        diff    = r_shift - {1'b0, opnd};
        if (div_mode) begin
            if (!diff[WIDTH]) begin
                acc_next = {{(WIDTH-1){1'b0}}, diff};
                sh_next  = {sh[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {{(WIDTH-1){1'b0}}, r_shift};
                sh_next  = {sh[WIDTH-2:0], 1'b0};
            end
            result = {1'b0, acc_next[WIDTH-1:0], sh_next};
        end
`endif
    end

endmodule

// File: rtl/ula_nbits.sv
// N-bit ALU top: request FSM, single-cycle ops and registered outputs around ula_seq_core.
// Define ULA_DIV_EN to compile in the iterative divider (op 0111); otherwise 0111 is an invalid opcode.
module ula_nbits
    import ula_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int OUT_W = 2*WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             sinal,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_ula,
    output logic [3:0]       flags
);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             core_load;
    logic             core_last;
    logic [OUT_W-1:0] core_result;
`ifdef ULA_DIV_EN
    logic             core_div;
`endif
    logic [WIDTH:0]   a_x;
    logic [WIDTH:0]   b_x;
    logic [WIDTH:0]   sum;
    logic             res_valid;
    logic [OUT_W-1:0] res_ula;
    logic [3:0]       res_flags;

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid && in_ready;

    ula_seq_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (core_load),
        .step   (state != ST_IDLE),
`ifdef ULA_DIV_EN
        .is_div (core_div),
`endif
        .a      (a),
        .b      (b),
        .result (core_result),
        .last   (core_last)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        core_load  = 1'b0;
`ifdef ULA_DIV_EN
        core_div   = 1'b0;
`endif
        res_valid  = 1'b0;
        res_ula    = '0;
        res_flags  = '0;
        a_x        = {sinal & a[WIDTH-1], a};
        b_x        = {sinal & b[WIDTH-1], b};
        sum        = (op == OP_SUB) ? a_x - b_x : a_x + b_x;

        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_ADD, OP_SUB: begin
                            res_valid           = 1'b1;
                            res_ula             = {{WIDTH{sinal & sum[WIDTH]}}, sum};
                            res_flags[FLAG_OVF] = sinal && (sum[WIDTH] != sum[WIDTH-1]);
                        end
                        OP_AND: begin
                            res_valid = 1'b1;
                            res_ula   = {{(WIDTH+1){1'b0}}, a & b};
                        end
                        OP_OR: begin
                            res_valid = 1'b1;
                            res_ula   = {{(WIDTH+1){1'b0}}, a | b};
                        end
                        OP_XOR: begin
                            res_valid = 1'b1;
                            res_ula   = {{(WIDTH+1){1'b0}}, a ^ b};
                        end
                        OP_MUL: begin
                            state_next = ST_MUL;
                            core_load  = 1'b1;
                        end
`ifdef ULA_DIV_EN
                        OP_DIV: begin
                            if (b != '0) begin
                                state_next = ST_DIV;
                                core_load  = 1'b1;
                                core_div   = 1'b1;
                            end else begin
                                // Divide by zero: quotient saturates, remainder passes a through.
                                res_valid          = 1'b1;
                                res_ula            = {1'b0, a, {WIDTH{1'b1}}};
                                res_flags[FLAG_DZ] = 1'b1;
                            end
                        end
`endif
                        default: begin
                            res_valid           = 1'b1;
                            res_flags[FLAG_ERR] = 1'b1;
                        end
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                if (core_last) begin
                    state_next = ST_IDLE;
                    res_valid  = 1'b1;
                    res_ula    = core_result;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        res_flags[FLAG_ZERO] = res_valid && (res_ula == '0);
    end

    // Result and flags only move on a completing cycle, so they hold between pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_ula   <= '0;
            flags     <= '0;
        end else begin
            out_valid <= res_valid;
            if (res_valid) begin
                out_ula <= res_ula;
                flags   <= res_flags;
            end
        end
    end

endmodule

// File: tb/tb_ula_nbits.sv
// Self-checking bench for ula_nbits (WIDTH=4): directed cases plus random ops against an arithmetic model.
// Honors ULA_DIV_EN when choosing the expected behaviour of op 0111.
module tb_ula_nbits;

    localparam int W       = 4;
    localparam int OW      = 2*W + 1;
    localparam int FULL    = 1 << W;
    localparam int HALF    = 1 << (W-1);
    localparam int OMASK   = (1 << OW) - 1;
    localparam int LAT_MAX = 40;

    localparam logic [3:0] T_ADD = 4'b0001;
    localparam logic [3:0] T_SUB = 4'b0010;
    localparam logic [3:0] T_MUL = 4'b0011;
    localparam logic [3:0] T_AND = 4'b0100;
    localparam logic [3:0] T_OR  = 4'b0101;
    localparam logic [3:0] T_XOR = 4'b0110;
    localparam logic [3:0] T_DIV = 4'b0111;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [3:0]    op = '0;
    logic          sinal = 1'b0;
    logic          out_valid;
    logic [OW-1:0] out_ula;
    logic [3:0]    flags;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ula_nbits #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .sinal     (sinal),
        .out_valid (out_valid),
        .out_ula   (out_ula),
        .flags     (flags)
    );

    // Reference: plain integer arithmetic; ef = {err, dz, ovf, zero}, el = cycles from accept to out_valid.
    function automatic void model(input int ai, input int bi, input logic [3:0] opi, input bit s,
                                  output int eu, output logic [3:0] ef, output int el);
        int sa, sb, r;
        eu = 0;
        ef = 4'b0000;
        el = 1;
        sa = (s && ai >= HALF) ? ai - FULL : ai;
        sb = (s && bi >= HALF) ? bi - FULL : bi;
        case (opi)
            T_ADD, T_SUB: begin
                r = (opi == T_ADD) ? sa + sb : sa - sb;
                if (s) begin
                    eu    = r & OMASK;
                    ef[1] = (r > HALF - 1) || (r < -HALF);
                end else begin
                    eu = r & (2*FULL - 1);
                end
            end
            T_AND: eu = ai & bi;
            T_OR:  eu = ai | bi;
            T_XOR: eu = ai ^ bi;
            T_MUL: begin
                eu = ai * bi;
                el = W + 1;
            end
`ifdef ULA_DIV_EN
            T_DIV: begin
                if (bi == 0) begin
                    eu    = ai * FULL + (FULL - 1);
                    ef[2] = 1'b1;
                end else begin
                    eu = (ai % bi) * FULL + ai / bi;
                    el = W + 1;
                end
            end
`endif
            default: ef[3] = 1'b1;
        endcase
        ef[0] = (eu == 0);
    endfunction

    // Issues one request and observes the response and the cycle that follows it.
    task automatic run_op(input int ai, input int bi, input logic [3:0] opi, input bit s,
                          output bit got, output int lat, output int busy,
                          output logic [OW-1:0] gu, output logic [3:0] gf,
                          output logic nv, output logic [OW-1:0] nu, output logic [3:0] nf);
        @(negedge clk);
        a = ai[W-1:0]; b = bi[W-1:0]; op = opi; sinal = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat  = 1;
        busy = 0;
        while (out_valid !== 1'b1 && lat < LAT_MAX) begin
            if (in_ready !== 1'b1) busy++;
            @(posedge clk); #1;
            lat++;
        end
        got = (out_valid === 1'b1);
        gu  = out_ula;
        gf  = flags;
        @(posedge clk); #1;
        nv = out_valid;
        nu = out_ula;
        nf = flags;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_ula !== '0 || flags !== 4'b0000) begin
            n_err++;
            $display("FAIL reset: in_ready=%b out_valid=%b out_ula=%h flags=%b, want 1 0 000 0000",
                     in_ready, out_valid, out_ula, flags);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_ops(input string name, input int ai, input int bi, input logic [3:0] opi, input bit s);
        bit got; int lat, busy, eu, el;
        logic [OW-1:0] gu, nu; logic [3:0] gf, nf, ef; logic nv;
        model(ai, bi, opi, s, eu, ef, el);
        run_op(ai, bi, opi, s, got, lat, busy, gu, gf, nv, nu, nf);
        n_cmp++;
        if (!got || lat != el) begin
            n_err++;
            $display("FAIL %s latency: got %0d (seen=%0b) want %0d", name, lat, got, el);
        end
        n_cmp++;
        if (gu !== eu[OW-1:0]) begin
            n_err++;
            $display("FAIL %s out_ula: got %h want %h (a=%0d b=%0d op=%b s=%0b)", name, gu, eu[OW-1:0], ai, bi, opi, s);
        end
        n_cmp++;
        if (gf !== ef) begin
            n_err++;
            $display("FAIL %s flags: got %b want %b (a=%0d b=%0d op=%b s=%0b)", name, gf, ef, ai, bi, opi, s);
        end
        n_cmp++;
        if (busy != el - 1) begin
            n_err++;
            $display("FAIL %s in_ready low cycles: got %0d want %0d", name, busy, el - 1);
        end
        n_cmp++;
        if (nv !== 1'b0 || nu !== eu[OW-1:0] || nf !== ef) begin
            n_err++;
            $display("FAIL %s hold after pulse: out_valid=%b out_ula=%h flags=%b want 0 %h %b", name, nv, nu, nf, eu[OW-1:0], ef);
        end
    endtask

    task automatic test_alu_single();
        test_ops("add_9_8",       9, 8,  T_ADD, 1'b0);
        test_ops("sub_7_m8",      7, 8,  T_SUB, 1'b1);
        test_ops("add_s_m8_m8",   8, 8,  T_ADD, 1'b1);
        test_ops("add_s_3_m3",    3, 13, T_ADD, 1'b1);
        test_ops("sub_u_7_8",     7, 8,  T_SUB, 1'b0);
        test_ops("add_u_15_15",  15, 15, T_ADD, 1'b0);
        test_ops("and_zero",      5, 10, T_AND, 1'b0);
        test_ops("or_5_10",       5, 10, T_OR,  1'b0);
        test_ops("xor_12_10",    12, 10, T_XOR, 1'b1);
    endtask

    task automatic test_mul_div();
        test_ops("mul_15_15", 15, 15, T_MUL, 1'b0);
        test_ops("mul_0_9",    0,  9, T_MUL, 1'b0);
        test_ops("mul_7_1",    7,  1, T_MUL, 1'b1);
        test_ops("div_13_4",  13,  4, T_DIV, 1'b0);
        test_ops("div_7_0",    7,  0, T_DIV, 1'b0);
        test_ops("div_15_1",  15,  1, T_DIV, 1'b0);
        test_ops("div_2_9",    2,  9, T_DIV, 1'b0);
    endtask

    task automatic test_invalid();
        test_ops("op_1111", 6, 3, 4'b1111, 1'b0);
        test_ops("op_0000", 6, 3, 4'b0000, 1'b1);
        test_ops("op_0111", 6, 3, T_DIV,   1'b0);
    endtask

    task automatic test_back_to_back();
        logic [3:0] sc_ops [6] = '{T_ADD, T_SUB, T_AND, T_OR, T_XOR, 4'b1010};
        for (int i = 0; i < 12; i++) begin
            int ai, bi, eu, el;
            logic [3:0] opi, ef;
            bit s;
            ai  = $urandom_range(0, FULL - 1);
            bi  = $urandom_range(0, FULL - 1);
            opi = sc_ops[$urandom_range(0, 5)];
            s   = 1'($urandom_range(0, 1));
            model(ai, bi, opi, s, eu, ef, el);
            @(negedge clk);
            a = ai[W-1:0]; b = bi[W-1:0]; op = opi; sinal = s; in_valid = 1'b1;
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_ula !== eu[OW-1:0] || flags !== ef) begin
                n_err++;
                $display("FAIL b2b[%0d]: valid=%b ready=%b out_ula=%h flags=%b want 1 1 %h %b (a=%0d b=%0d op=%b s=%0b)",
                         i, out_valid, in_ready, out_ula, flags, eu[OW-1:0], ef, ai, bi, opi, s);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_busy_ignore();
        int eu, el;
        logic [3:0] ef;
        model(13, 11, T_MUL, 1'b0, eu, ef, el);
        @(negedge clk);
        a = 4'd13; b = 4'd11; op = T_MUL; sinal = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 4'd3; b = 4'd4; op = T_ADD;
        repeat (W - 1) begin
            n_cmp++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL busy_ignore busy: out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_ula !== eu[OW-1:0] || flags !== ef) begin
            n_err++;
            $display("FAIL busy_ignore result: valid=%b out_ula=%h flags=%b want 1 %h %b", out_valid, out_ula, flags, eu[OW-1:0], ef);
        end
        repeat (2) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b0 || out_ula !== eu[OW-1:0] || flags !== ef) begin
                n_err++;
                $display("FAIL busy_ignore hold: valid=%b out_ula=%h flags=%b want 0 %h %b", out_valid, out_ula, flags, eu[OW-1:0], ef);
            end
        end
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        test_ops("pre_abort_add", 9, 8, T_ADD, 1'b0);
        @(negedge clk);
        a = 4'd15; b = 4'd15; op = T_MUL; sinal = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ula !== '0 || flags !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_abort: valid=%b ready=%b out_ula=%h flags=%b want 0 1 000 0000", out_valid, in_ready, out_ula, flags);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL reset_abort late pulse: got %0d out_valid cycles want 0", seen);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 120; i++) begin
            int r;
            logic [3:0] opi;
            r   = $urandom_range(0, 9);
            opi = (r <= 6) ? 4'(r + 1) : 4'($urandom_range(0, 15));
            test_ops($sformatf("rand%0d", i), $urandom_range(0, FULL - 1), $urandom_range(0, FULL - 1),
                     opi, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_alu_single();
        test_mul_div();
        test_invalid();
        test_back_to_back();
        test_busy_ignore();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
